// File: rtl/reset_seq_pkg.sv
// Shared constants for the reset sequencer: FSM encoding, reset-cause codes
// and a counter width helper.
package reset_seq_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_BTN   = 2'b01;
    localparam logic [1:0] CAUSE_SW    = 2'b10;
    localparam logic [1:0] CAUSE_WDT   = 2'b11;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_seq_debounce.sv
// Board push-button conditioning: 2-flop synchroniser followed by a saturating
// low-level debounce counter with a registered trigger.
module reset_debounce
    import reset_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_ext_resetn,
    output logic o_btn_trig,
    output logic o_btn_level
);

    localparam int unsigned CW = cnt_width(DEBOUNCE);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_trig;

    // Synchroniser resets to the released (high) level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_ext_resetn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_sync2) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(DEBOUNCE)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig <= 1'b0;
        end else begin
            r_trig <= (r_cnt == CW'(DEBOUNCE));
        end
    end

    assign o_btn_trig  = r_trig;
    assign o_btn_level = r_sync2;

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: merges PLL reset, debounced button and software request,
// stretches, then releases NUM_OUT active-low resets in a staggered order.
// Optional watchdog trigger enabled by defining RESET_SEQ_WDT_EN.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_OUT     = 3,
    parameter int unsigned STRETCH     = 8,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned DEBOUNCE    = 16,
    parameter int unsigned WDT_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ext_resetn,
    input  logic               sw_reset_req,
    input  logic               wdt_kick,
    output logic [NUM_OUT-1:0] resetn_o,
    output logic               all_released,
    output logic [1:0]         reset_cause
);

    localparam int unsigned CNT_MAX = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int unsigned CW      = cnt_width(CNT_MAX);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [NUM_OUT-1:0] r_resetn;
    logic               r_all;
    logic [1:0]         r_cause;

    logic [1:0]         w_state_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [NUM_OUT-1:0] w_resetn_nxt;
    logic [1:0]         w_cause_nxt;
    logic               w_btn_trig;
    logic               w_btn_level;
    logic               w_wdt_expire;
    logic               w_trig;
    logic               w_unused;

    reset_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .i_ext_resetn (ext_resetn),
        .o_btn_trig   (w_btn_trig),
        .o_btn_level  (w_btn_level)
    );

`ifdef RESET_SEQ_WDT_EN
    localparam int unsigned WW = cnt_width(WDT_TIMEOUT);

    logic [WW-1:0] r_wdt_cnt;

    // Watchdog only ages while the system is fully released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdt_cnt <= '0;
        end else if ((r_state != ST_RUN) || wdt_kick || w_trig) begin
            r_wdt_cnt <= '0;
        end else if (r_wdt_cnt != WW'(WDT_TIMEOUT)) begin
            r_wdt_cnt <= r_wdt_cnt + WW'(1);
        end
    end

    assign w_wdt_expire = (r_state == ST_RUN) && (r_wdt_cnt == WW'(WDT_TIMEOUT));
    assign w_unused     = w_btn_level;
`else
    assign w_wdt_expire = 1'b0;
    assign w_unused     = ^{wdt_kick, w_btn_level, (WDT_TIMEOUT == 0)};
`endif

    assign w_trig = w_btn_trig | sw_reset_req | w_wdt_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_resetn <= '0;
            r_all    <= 1'b0;
            r_cause  <= CAUSE_RESET;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_resetn <= w_resetn_nxt;
            r_all    <= &w_resetn_nxt;
            r_cause  <= w_cause_nxt;
        end
    end

    // Released bits form a thermometer code growing from bit 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_resetn_nxt = r_resetn;
        w_cause_nxt  = r_cause;
        if (w_trig) begin
            w_state_nxt  = ST_HOLD;
            w_cnt_nxt    = '0;
            w_resetn_nxt = '0;
            if (w_btn_trig) begin
                w_cause_nxt = CAUSE_BTN;
            end else if (sw_reset_req) begin
                w_cause_nxt = CAUSE_SW;
            end else begin
                w_cause_nxt = CAUSE_WDT;
            end
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_state_nxt = ST_STRETCH;
                    w_cnt_nxt   = '0;
                end
                ST_STRETCH: begin
                    if (r_cnt == CW'(STRETCH - 1)) begin
                        w_cnt_nxt    = '0;
                        w_resetn_nxt = NUM_OUT'(1);
                        w_state_nxt  = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == CW'(STAGGER - 1)) begin
                        w_cnt_nxt    = '0;
                        w_resetn_nxt = (r_resetn << 1) | NUM_OUT'(1);
                        if (w_resetn_nxt[NUM_OUT-1]) begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign resetn_o     = r_resetn;
    assign all_released = r_all;
    assign reset_cause  = r_cause;

endmodule
